// File: rtl/branch_predict_if.sv
// Fetch/EX-side signal bundle for the branch predictor: lookup request/response
// plus the training port driven from EX.
interface branch_predict_if #(
    parameter int DATA_WITDH = 32
);
    logic [DATA_WITDH-1:0] if_pc;
    logic                  pred_taken;
    logic [DATA_WITDH-1:0] pred_target;
    logic                  ex_upd_en;
    logic [DATA_WITDH-1:0] ex_upd_pc;
    logic                  ex_upd_taken;
    logic                  ex_upd_jalx;
    logic [DATA_WITDH-1:0] ex_upd_target;
    logic                  ex_upd_pred;
    logic                  bp_clear;

    modport master (
        output if_pc, ex_upd_en, ex_upd_pc, ex_upd_taken, ex_upd_jalx,
               ex_upd_target, ex_upd_pred, bp_clear,
        input  pred_taken, pred_target
    );

    modport slave (
        input  if_pc, ex_upd_en, ex_upd_pc, ex_upd_taken, ex_upd_jalx,
               ex_upd_target, ex_upd_pred, bp_clear,
        output pred_taken, pred_target
    );
endinterface

// File: rtl/branch_predict.sv
// Direct-mapped 2-bit-counter branch predictor with targets; combinational lookup,
// trained by EX. Define BRANCH_PREDICT_STATS_EN to add lookup/mispredict counters.
module branch_predict #(
    parameter int DATA_WITDH = 32,
    parameter int ENTRIES    = 16,
    parameter int IDX_W      = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic                rst_n,
    branch_predict_if.slave     bp
`ifdef BRANCH_PREDICT_STATS_EN
    ,
    output logic [31:0]         lookup_cnt,
    output logic [31:0]         mispredict_cnt
`endif
);
    localparam int TAG_W = DATA_WITDH - IDX_W - 2;

    logic [ENTRIES-1:0]                 valid_q;
    logic [ENTRIES-1:0][TAG_W-1:0]      tag_q;
    logic [ENTRIES-1:0][DATA_WITDH-1:0] tgt_q;
    logic [ENTRIES-1:0][1:0]            ctr_q;

    // Lookup: pure read of registered state, no bypass from a same-cycle update.
    logic [IDX_W-1:0] l_idx;
    logic             l_hit;

    assign l_idx          = bp.if_pc[IDX_W+1:2];
    assign l_hit          = valid_q[l_idx] && (tag_q[l_idx] == bp.if_pc[DATA_WITDH-1:IDX_W+2]);
    assign bp.pred_taken  = l_hit && ctr_q[l_idx][1];
    assign bp.pred_target = bp.pred_taken ? tgt_q[l_idx] : bp.if_pc + DATA_WITDH'(4);

    logic [IDX_W-1:0]      u_idx;
    logic [TAG_W-1:0]      u_tag;
    logic                  u_hit;
    logic                  wr_en;
    logic                  alloc;
    logic [1:0]            ctr_d;
    logic [DATA_WITDH-1:0] tgt_d;

    assign u_idx = bp.ex_upd_pc[IDX_W+1:2];
    assign u_tag = bp.ex_upd_pc[DATA_WITDH-1:IDX_W+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    always_comb begin
        wr_en = 1'b0;
        alloc = 1'b0;
        ctr_d = ctr_q[u_idx];
        tgt_d = tgt_q[u_idx];
        if (bp.ex_upd_en) begin
            if (u_hit) begin
                wr_en = 1'b1;
                if (bp.ex_upd_jalx) begin
                    ctr_d = 2'd3;
                    tgt_d = bp.ex_upd_target;
                end else if (bp.ex_upd_taken) begin
                    ctr_d = (ctr_q[u_idx] == 2'd3) ? 2'd3 : ctr_q[u_idx] + 2'd1;
                    tgt_d = bp.ex_upd_target;
                end else begin
                    ctr_d = (ctr_q[u_idx] == 2'd0) ? 2'd0 : ctr_q[u_idx] - 2'd1;
                end
            end else if (bp.ex_upd_taken || bp.ex_upd_jalx) begin
                // Not-taken misses never allocate, so cold branches stay out of the table.
                wr_en = 1'b1;
                alloc = 1'b1;
                ctr_d = bp.ex_upd_jalx ? 2'd3 : 2'd2;
                tgt_d = bp.ex_upd_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= 2'd1;
            end
        end else if (bp.bp_clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'd1;
            end
        end else if (wr_en) begin
            ctr_q[u_idx] <= ctr_d;
            tgt_q[u_idx] <= tgt_d;
            if (alloc) begin
                valid_q[u_idx] <= 1'b1;
                tag_q[u_idx]   <= u_tag;
            end
        end
    end

`ifdef BRANCH_PREDICT_STATS_EN
    logic [31:0] lookup_cnt_q;
    logic [31:0] mispredict_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookup_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            lookup_cnt_q <= lookup_cnt_q + 32'd1;
            if (bp.ex_upd_en && (bp.ex_upd_pred != (bp.ex_upd_taken || bp.ex_upd_jalx)))
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
        end
    end

    assign lookup_cnt     = lookup_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;
`endif
endmodule

// File: tb/tb_branch_predict.sv
// Directed vector bench for branch_predict: each vector is checked on the lookup
// before its clock edge, so a vector's update is observed by the following one.
module tb_branch_predict;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predict_if #(.DATA_WITDH(32)) bp_if ();

`ifdef BRANCH_PREDICT_STATS_EN
    logic [31:0] lookup_cnt, mispredict_cnt;
`endif

    branch_predict #(.DATA_WITDH(32), .ENTRIES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp_if.slave)
`ifdef BRANCH_PREDICT_STATS_EN
        ,
        .lookup_cnt     (lookup_cnt),
        .mispredict_cnt (mispredict_cnt)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic        en;
        logic [31:0] upc;
        logic        tk;
        logic        jx;
        logic [31:0] tgt;
        logic        clr;
        logic        exp_tk;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic [31:0] pc, logic en, logic [31:0] upc, logic tk,
                                logic jx, logic [31:0] tgt, logic clr,
                                logic exp_tk, logic [31:0] exp_tgt);
        vec_t v;
        v.pc = pc; v.en = en; v.upc = upc; v.tk = tk; v.jx = jx; v.tgt = tgt;
        v.clr = clr; v.exp_tk = exp_tk; v.exp_tgt = exp_tgt;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        bp_if.if_pc         = v.pc;
        bp_if.ex_upd_en     = v.en;
        bp_if.ex_upd_pc     = v.upc;
        bp_if.ex_upd_taken  = v.tk;
        bp_if.ex_upd_jalx   = v.jx;
        bp_if.ex_upd_target = v.tgt;
        bp_if.ex_upd_pred   = 1'b0;
        bp_if.bp_clear      = v.clr;
    endtask

    initial begin
        //            if_pc        en upd_pc      tk jx target       clr exp_tk exp_tgt
        vecs.push_back(mk(32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h104)); // cold miss
        vecs.push_back(mk(32'h100, 1, 32'h100, 1, 0, 32'h40,  0, 0, 32'h104)); // alloc ctr=2
        vecs.push_back(mk(32'h100, 1, 32'h100, 0, 0, 32'h0,   0, 1, 32'h40));  // 2->1
        vecs.push_back(mk(32'h100, 1, 32'h100, 0, 0, 32'h0,   0, 0, 32'h104)); // 1->0
        vecs.push_back(mk(32'h100, 1, 32'h100, 0, 0, 32'h0,   0, 0, 32'h104)); // stays 0
        vecs.push_back(mk(32'h100, 1, 32'h100, 1, 0, 32'h40,  0, 0, 32'h104)); // 0->1
        vecs.push_back(mk(32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h104)); // ctr 1
        vecs.push_back(mk(32'h200, 1, 32'h200, 0, 1, 32'h800, 0, 0, 32'h204)); // jalx alloc
        vecs.push_back(mk(32'h200, 1, 32'h240, 1, 0, 32'h900, 0, 1, 32'h800)); // alias replaces
        vecs.push_back(mk(32'h200, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h204)); // evicted
        vecs.push_back(mk(32'h240, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h900));
        vecs.push_back(mk(32'h300, 1, 32'h300, 1, 0, 32'h500, 0, 0, 32'h304)); // no bypass
        vecs.push_back(mk(32'h300, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h500));
        vecs.push_back(mk(32'h340, 1, 32'h380, 0, 0, 32'h0,   0, 0, 32'h344)); // NT miss no alloc
        vecs.push_back(mk(32'h300, 1, 32'h300, 1, 0, 32'h600, 1, 1, 32'h500)); // clear wins
        vecs.push_back(mk(32'h300, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h304));
        vecs.push_back(mk(32'hFFFFFFFC, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0));  // wrap
        vecs.push_back(mk(32'h400, 1, 32'h400, 1, 0, 32'hA00, 0, 0, 32'h404)); // alloc 2
        vecs.push_back(mk(32'h400, 1, 32'h400, 1, 0, 32'hB00, 0, 1, 32'hA00)); // 2->3
        vecs.push_back(mk(32'h400, 1, 32'h400, 1, 0, 32'hB00, 0, 1, 32'hB00)); // sat 3
        vecs.push_back(mk(32'h400, 1, 32'h400, 0, 0, 32'hDEAD, 0, 1, 32'hB00)); // 3->2
        vecs.push_back(mk(32'h400, 1, 32'h400, 0, 0, 32'h0,   0, 1, 32'hB00)); // 2->1
        vecs.push_back(mk(32'h400, 1, 32'h400, 0, 1, 32'hC00, 0, 0, 32'h404)); // jalx hit ->3
        vecs.push_back(mk(32'h400, 1, 32'h400, 0, 0, 32'h0,   0, 1, 32'hC00)); // 3->2
        vecs.push_back(mk(32'h400, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'hC00));

        drive(mk(32'h100, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("reset_taken",  32'(bp_if.pred_taken), 32'd0);
        chk("reset_target", bp_if.pred_target, 32'h104);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_taken", i),  32'(bp_if.pred_taken), 32'(vecs[i].exp_tk));
            chk($sformatf("v%0d_target", i), bp_if.pred_target, vecs[i].exp_tgt);
        end

        // Async reset while an update is pending: table must read empty at once and after.
        @(negedge clk);
        drive(mk(32'h400, 1, 32'h400, 1, 0, 32'hE00, 0, 0, 0));
        #1;
        chk("pre_rst_taken", 32'(bp_if.pred_taken), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_taken",  32'(bp_if.pred_taken), 32'd0);
        chk("async_rst_target", bp_if.pred_target, 32'h404);
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk(32'h400, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        #1;
        chk("post_rst_taken",  32'(bp_if.pred_taken), 32'd0);
        chk("post_rst_target", bp_if.pred_target, 32'h404);

`ifdef BRANCH_PREDICT_STATS_EN
        begin
            logic [31:0] l0, m0;
            l0 = lookup_cnt;
            m0 = mispredict_cnt;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                bp_if.ex_upd_en    = 1'b1;
                bp_if.ex_upd_pc    = 32'h600 + 32'(k * 4);
                bp_if.ex_upd_taken = 1'b1;
                bp_if.ex_upd_jalx  = 1'b0;
                bp_if.ex_upd_pred  = (k >= 3);
                bp_if.bp_clear     = (k == 1);
            end
            @(negedge clk);
            bp_if.ex_upd_en = 1'b0;
            bp_if.bp_clear  = 1'b0;
            #1;
            chk("mispredict_delta", mispredict_cnt - m0, 32'd3);
            chk("lookup_delta",     lookup_cnt - l0,     32'd6);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
